// File: rtl/lut_loader.sv
// Streams SD-reader bytes into double-buffered H/V stripe LUTs, verifies an optional
// modulo-256 checksum, and publishes the new bank only on a vsync rising edge.
module lut_loader #(
  parameter int H_LEN    = 720,
  parameter int V_LEN    = 1280,
  parameter int CHECK_EN = 1
) (
  input  logic        clk10,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_eof,
  input  logic        vsync_s,
  output logic        wr_en,
  output logic        wr_sel,
  output logic        wr_bank,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_bank,
  output logic        lut_rdy,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_H  = 3'd1;
  localparam logic [2:0] S_LOAD_V  = 3'd2;
  localparam logic [2:0] S_LOAD_CK = 3'd3;
  localparam logic [2:0] S_PEND    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [10:0] H_LAST = 11'(H_LEN - 1);
  localparam logic [10:0] V_LAST = 11'(V_LEN - 1);

  logic [2:0]  state, state_n;
  logic [10:0] count, count_n;
  logic [7:0]  sum, sum_n;
  logic        vsync_q;
  logic        vsync_rise;
  logic        swap;
  logic        err_n;
  logic [1:0]  code_n;
  logic        wr_en_n, wr_sel_n;
  logic [10:0] wr_addr_n;
  logic [7:0]  wr_data_n;

  assign vsync_rise = vsync_s & ~vsync_q;
  assign wr_bank    = ~rd_bank;
  assign busy       = (state == S_LOAD_H) || (state == S_LOAD_V) ||
                      (state == S_LOAD_CK) || (state == S_PEND);

  always_comb begin
    state_n   = state;
    count_n   = count;
    sum_n     = sum;
    err_n     = err;
    code_n    = err_code;
    wr_en_n   = 1'b0;
    wr_sel_n  = wr_sel;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    swap      = 1'b0;

    if (start) begin
      state_n = S_LOAD_H;
      count_n = '0;
      sum_n   = '0;
      err_n   = 1'b0;
      code_n  = 2'b00;
    end else begin
      case (state)
        S_LOAD_H, S_LOAD_V: begin
          if (in_valid) begin
            wr_en_n   = 1'b1;
            wr_sel_n  = (state == S_LOAD_V);
            wr_addr_n = count;
            wr_data_n = in_byte;
            sum_n     = sum + in_byte;
            count_n   = count + 11'd1;
            if (state == S_LOAD_H && count == H_LAST) begin
              state_n = S_LOAD_V;
              count_n = '0;
            end else if (state == S_LOAD_V && count == V_LAST) begin
              state_n = (CHECK_EN != 0) ? S_LOAD_CK : S_PEND;
              count_n = '0;
            end
          end
        end
        S_LOAD_CK: begin
          if (in_valid) begin
            if (in_byte == sum) begin
              state_n = S_PEND;
            end else begin
              state_n = S_ERR;
              err_n   = 1'b1;
              code_n  = 2'b11;
            end
          end
        end
        S_PEND: begin
          // Any extra byte means the file was longer than expected, so never publish it.
          if (in_valid) begin
            state_n = S_ERR;
            err_n   = 1'b1;
            code_n  = 2'b10;
          end else if (vsync_rise) begin
            swap    = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: ;
      endcase

      // End-of-file is judged after this cycle's byte has been consumed.
      if (in_eof && (state_n == S_LOAD_H || state_n == S_LOAD_V || state_n == S_LOAD_CK)) begin
        state_n = S_ERR;
        err_n   = 1'b1;
        code_n  = 2'b01;
      end
    end
  end

  always_ff @(posedge clk10) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      sum      <= '0;
      vsync_q  <= 1'b0;
      rd_bank  <= 1'b0;
      lut_rdy  <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      sum      <= sum_n;
      vsync_q  <= vsync_s;
      rd_bank  <= rd_bank ^ swap;
      lut_rdy  <= lut_rdy | swap;
      err      <= err_n;
      err_code <= code_n;
      wr_en    <= wr_en_n;
      wr_sel   <= wr_sel_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader: nominal, checksum, short/long file, back-to-back
// and mid-load reset scenarios with a write monitor checking every LUT write.
module tb_lut_loader;

  logic        clk10 = 1'b0;
  logic        rst, start, in_valid, in_eof, vsync_s;
  logic [7:0]  in_byte;
  logic        wr_en, wr_sel, wr_bank, rd_bank, lut_rdy, busy, err;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  err_code;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  logic        last_sel;
  logic [10:0] last_addr;

  lut_loader #(.H_LEN(720), .V_LEN(1280), .CHECK_EN(1)) dut (
    .clk10(clk10), .rst(rst), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_eof(in_eof), .vsync_s(vsync_s),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .lut_rdy(lut_rdy), .busy(busy),
    .err(err), .err_code(err_code)
  );

  always #5 clk10 = ~clk10;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] pattern(input int i);
    if (i < 720) return 8'(i);
    return 8'hFF - 8'(i - 720);
  endfunction

  task automatic tick();
    @(posedge clk10);
    #1;
  endtask

  // Start a load, stream n bytes, optionally append checksum+delta, optionally
  // raise vsync together with the last byte sent.
  task automatic applyStimulus(input int n, input bit send_ck, input logic [7:0] ck_delta,
                               input bit vsync_on_last);
    logic [7:0] s;
    s = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_byte  = pattern(i);
      s        = s + pattern(i);
      if (!send_ck && vsync_on_last && i == n - 1) vsync_s = 1'b1;
      tick();
    end
    if (send_ck) begin
      in_valid = 1'b1;
      in_byte  = s + ck_delta;
      vsync_s  = vsync_on_last;
      tick();
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
    vsync_s  = 1'b0;
    tick();
  endtask

  task automatic pulse_vsync();
    vsync_s = 1'b1;
    tick();
    vsync_s = 1'b0;
  endtask

  // Every write is checked against the stream order since the last start.
  always @(negedge clk10) begin
    if (start) wr_count = 0;
    if (wr_en) begin
      checkOutput("wr_sel",  32'(wr_sel),  32'(wr_count >= 720));
      checkOutput("wr_addr", 32'(wr_addr), (wr_count < 720) ? 32'(wr_count) : 32'(wr_count - 720));
      checkOutput("wr_data", 32'(wr_data), 32'(pattern(wr_count)));
      checkOutput("wr_bank", 32'(wr_bank), 32'(!rd_bank));
      last_sel  = wr_sel;
      last_addr = wr_addr;
      wr_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_eof = 1'b0; vsync_s = 1'b0; in_byte = 8'h00;
    repeat (3) tick();
    checkOutput("rst_rd_bank",  32'(rd_bank),  0);
    checkOutput("rst_wr_bank",  32'(wr_bank),  1);
    checkOutput("rst_lut_rdy",  32'(lut_rdy),  0);
    checkOutput("rst_busy",     32'(busy),     0);
    checkOutput("rst_err",      32'(err),      0);
    checkOutput("rst_err_code", 32'(err_code), 0);
    checkOutput("rst_wr_en",    32'(wr_en),    0);
    rst = 1'b0;
    tick();

    $display("[TB] checksum error load");
    applyStimulus(2000, 1'b1, 8'd1, 1'b0);
    checkOutput("ck_err",      32'(err),      1);
    checkOutput("ck_err_code", 32'(err_code), 3);
    checkOutput("ck_busy",     32'(busy),     0);
    pulse_vsync();
    checkOutput("ck_rd_bank",  32'(rd_bank),  0);
    checkOutput("ck_lut_rdy",  32'(lut_rdy),  0);
    tick();

    $display("[TB] nominal load");
    applyStimulus(2000, 1'b1, 8'd0, 1'b0);
    checkOutput("nom_writes",  32'(wr_count), 2000);
    checkOutput("nom_busy",    32'(busy),     1);
    checkOutput("nom_err",     32'(err),      0);
    checkOutput("nom_pre_rd",  32'(rd_bank),  0);
    pulse_vsync();
    checkOutput("nom_rd_bank", 32'(rd_bank),  1);
    checkOutput("nom_wr_bank", 32'(wr_bank),  0);
    checkOutput("nom_lut_rdy", 32'(lut_rdy),  1);
    checkOutput("nom_idle",    32'(busy),     0);
    tick();

    $display("[TB] short file");
    applyStimulus(1000, 1'b0, 8'd0, 1'b0);
    in_eof = 1'b1;
    tick();
    in_eof = 1'b0;
    checkOutput("short_err_code",  32'(err_code),  1);
    checkOutput("short_err",       32'(err),       1);
    checkOutput("short_writes",    32'(wr_count),  1000);
    checkOutput("short_last_sel",  32'(last_sel),  1);
    checkOutput("short_last_addr", 32'(last_addr), 279);
    checkOutput("short_rd_bank",   32'(rd_bank),   1);

    $display("[TB] long file");
    applyStimulus(2000, 1'b1, 8'd0, 1'b0);
    checkOutput("long_pend", 32'(busy), 1);
    in_valid = 1'b1; in_byte = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("long_err_code", 32'(err_code), 2);
    pulse_vsync();
    checkOutput("long_rd_bank",  32'(rd_bank),  1);
    checkOutput("long_lut_rdy",  32'(lut_rdy),  1);
    tick();

    $display("[TB] reset mid-load");
    applyStimulus(500, 1'b0, 8'd0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_byte = pattern(500);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("mrst_rd_bank",  32'(rd_bank),  0);
    checkOutput("mrst_wr_bank",  32'(wr_bank),  1);
    checkOutput("mrst_lut_rdy",  32'(lut_rdy),  0);
    checkOutput("mrst_busy",     32'(busy),     0);
    checkOutput("mrst_err",      32'(err),      0);
    checkOutput("mrst_err_code", 32'(err_code), 0);
    checkOutput("mrst_wr_en",    32'(wr_en),    0);
    checkOutput("mrst_wr_sel",   32'(wr_sel),   0);
    checkOutput("mrst_wr_addr",  32'(wr_addr),  0);
    checkOutput("mrst_wr_data",  32'(wr_data),  0);
    tick();

    $display("[TB] back-to-back loads");
    applyStimulus(2000, 1'b1, 8'd0, 1'b0);
    checkOutput("b2b1_writes", 32'(wr_count), 2000);
    pulse_vsync();
    checkOutput("b2b1_rd_bank", 32'(rd_bank), 1);
    checkOutput("b2b1_wr_bank", 32'(wr_bank), 0);
    tick();
    applyStimulus(2000, 1'b1, 8'd0, 1'b1);
    checkOutput("b2b2_edge_ignored", 32'(rd_bank), 1);
    checkOutput("b2b2_still_pend",   32'(busy),    1);
    pulse_vsync();
    checkOutput("b2b2_rd_bank", 32'(rd_bank), 0);
    checkOutput("b2b2_wr_bank", 32'(wr_bank), 1);
    tick();
    applyStimulus(2000, 1'b1, 8'd7, 1'b0);
    checkOutput("b2b3_err_code", 32'(err_code), 3);
    pulse_vsync();
    checkOutput("b2b3_rd_bank", 32'(rd_bank), 0);
    checkOutput("b2b3_lut_rdy", 32'(lut_rdy), 1);
    tick();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
